// File: rtl/ray_dispatcher_pkg.sv
// ray_dispatcher_pkg: shared definitions for the ray dispatcher slice.
//   SCREEN_WIDTH / SCREEN_HEIGHT : default frame geometry (mirrors common_defs)
//   rgb_t                        : packed {r,g,b} pixel, 8 bits per channel
//   disp_state_t                 : dispatcher FSM states
package ray_dispatcher_pkg;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } disp_state_t;

endpackage

// File: rtl/ray_dispatcher_rr_picker.sv
// rr_picker: combinational round-robin first-one finder.
//   ready_mask : per-lane idle flags
//   start_idx  : lane index where the search begins (wraps around)
//   found      : at least one lane is ready
//   pick_idx   : first ready lane at or after start_idx
module rr_picker
#(
    parameter int NUM_UNITS = 4,
    parameter int IDX_W     = 2
)
(
    input  logic [NUM_UNITS-1:0] ready_mask,
    input  logic [IDX_W-1:0]     start_idx,
    output logic                 found,
    output logic [IDX_W-1:0]     pick_idx
);
    import ray_dispatcher_pkg::*;

    logic [IDX_W-1:0] cand_s;

    // Walk the lanes starting at start_idx; the first ready one wins.
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        cand_s   = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            cand_s = IDX_W'((int'(start_idx) + k) % NUM_UNITS);
            if (!found && ready_mask[cand_s]) begin
                found    = 1'b1;
                pick_idx = cand_s;
            end else begin
                found    = found;
            end
        end
    end

endmodule

// File: rtl/ray_dispatcher.sv
// ray_dispatcher: issues raster-order pixel coordinates to free ray lanes
// (round-robin), collects possibly out-of-order results in a reorder buffer
// and retires them in raster order with sof/eol framing.
//   aclk, aresetn          : clock, async active-low reset
//   enable                 : start a frame (sampled in IDLE only)
//   issue_x/issue_y        : coordinate broadcast to the lanes
//   issue_valid/unit_ready : one-hot issue strobe / lane idle flags
//   res_valid/res_rgb      : lane result strobes and data (lane i at [24i+:24])
//   r,g,b,valid,ready      : retired pixel stream to the packer
//   sof,eol                : first pixel of frame / last pixel of line
//   busy, frame_done       : activity flag / end-of-frame pulse
module ray_dispatcher
#(
    parameter int NUM_UNITS     = 4,
    parameter int ROB_DEPTH     = 8,
    parameter int SCREEN_WIDTH  = ray_dispatcher_pkg::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = ray_dispatcher_pkg::SCREEN_HEIGHT
)
(
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    enable,
    output logic [9:0]              issue_x,
    output logic [8:0]              issue_y,
    output logic [NUM_UNITS-1:0]    issue_valid,
    input  logic [NUM_UNITS-1:0]    unit_ready,
    input  logic [NUM_UNITS-1:0]    res_valid,
    input  logic [24*NUM_UNITS-1:0] res_rgb,
    output logic [7:0]              r,
    output logic [7:0]              g,
    output logic [7:0]              b,
    output logic                    valid,
    input  logic                    ready,
    output logic                    sof,
    output logic                    eol,
    output logic                    busy,
    output logic                    frame_done
);
    import ray_dispatcher_pkg::*;

    localparam int UIDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int PTR_W  = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;
    localparam int CNT_W  = $clog2(ROB_DEPTH + 1);
    localparam logic [9:0] X_LAST = 10'(SCREEN_WIDTH - 1);
    localparam logic [8:0] Y_LAST = 9'(SCREEN_HEIGHT - 1);

    disp_state_t          state_r;
    logic [9:0]           x_r, rx_r;
    logic [8:0]           y_r, ry_r;
    logic [PTR_W-1:0]     head_r, tail_r;
    logic [CNT_W-1:0]     alloc_count_r;
    logic [UIDX_W-1:0]    rr_ptr_r;
    logic [NUM_UNITS-1:0] unit_busy_r, busy_next_s;
    logic [PTR_W-1:0]     unit_tag_r [NUM_UNITS];
    logic [ROB_DEPTH-1:0] filled_r, filled_next_s;
    rgb_t                 rob_r [ROB_DEPTH];
    logic                 frame_done_r;

    logic                 pick_found_s;
    logic [UIDX_W-1:0]    pick_idx_s;
    logic                 can_issue_s, do_retire_s, last_pix_s, drain_done_s;
    rgb_t                 head_rgb_s;

    // Wrap a ROB pointer explicitly so non-exact widths stay in range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ROB_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    rr_picker #(.NUM_UNITS(NUM_UNITS), .IDX_W(UIDX_W)) u_rr_picker (
        .ready_mask (unit_ready),
        .start_idx  (rr_ptr_r),
        .found      (pick_found_s),
        .pick_idx   (pick_idx_s)
    );

    assign can_issue_s  = (state_r == ST_RUN) && (alloc_count_r < CNT_W'(ROB_DEPTH)) && pick_found_s;
    assign do_retire_s  = filled_r[head_r] && ready;
    assign last_pix_s   = (x_r == X_LAST) && (y_r == Y_LAST);
    assign drain_done_s = (alloc_count_r == '0) && (unit_busy_r == '0);
    assign head_rgb_s   = rob_r[head_r];
    assign issue_x      = x_r;
    assign issue_y      = y_r;
    assign busy         = (state_r != ST_IDLE);
    assign frame_done   = frame_done_r;

    // One-hot issue strobe toward the picked lane.
    always_comb begin
        issue_valid = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (can_issue_s && (pick_idx_s == UIDX_W'(i))) begin
                issue_valid[i] = 1'b1;
            end else begin
                issue_valid[i] = 1'b0;
            end
        end
    end

    // Retire-side outputs; forced to zero while the head slot is empty.
    always_comb begin
        if (filled_r[head_r]) begin
            valid = 1'b1;
            r     = head_rgb_s.r;
            g     = head_rgb_s.g;
            b     = head_rgb_s.b;
            sof   = (rx_r == 10'd0) && (ry_r == 9'd0);
            eol   = (rx_r == X_LAST);
        end else begin
            valid = 1'b0;
            r     = 8'd0;
            g     = 8'd0;
            b     = 8'd0;
            sof   = 1'b0;
            eol   = 1'b0;
        end
    end

    // Next filled/busy vectors: retire clears, lane results fill, issue marks lane busy.
    always_comb begin
        filled_next_s = filled_r;
        busy_next_s   = unit_busy_r;
        if (do_retire_s) begin
            filled_next_s[head_r] = 1'b0;
        end else begin
            filled_next_s = filled_next_s;
        end
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (res_valid[i] && unit_busy_r[i]) begin
                filled_next_s[unit_tag_r[i]] = 1'b1;
                busy_next_s[i]               = 1'b0;
            end else begin
                busy_next_s[i] = busy_next_s[i];
            end
        end
        if (can_issue_s) begin
            busy_next_s[pick_idx_s] = 1'b1;
        end else begin
            busy_next_s = busy_next_s;
        end
    end

    // Reorder buffer storage, pointers, occupancy and lane bookkeeping.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            head_r        <= '0;
            tail_r        <= '0;
            alloc_count_r <= '0;
            rr_ptr_r      <= '0;
            unit_busy_r   <= '0;
            filled_r      <= '0;
            for (int i = 0; i < NUM_UNITS; i++) begin
                unit_tag_r[i] <= '0;
            end
            for (int k = 0; k < ROB_DEPTH; k++) begin
                rob_r[k] <= '0;
            end
        end else begin
            unit_busy_r <= busy_next_s;
            filled_r    <= filled_next_s;
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (res_valid[i] && unit_busy_r[i]) begin
                    rob_r[unit_tag_r[i]] <= res_rgb[24*i +: 24];
                end
            end
            if (can_issue_s) begin
                unit_tag_r[pick_idx_s] <= tail_r;
                tail_r                 <= ptr_inc(tail_r);
                rr_ptr_r               <= (pick_idx_s == UIDX_W'(NUM_UNITS - 1)) ? '0 : pick_idx_s + UIDX_W'(1);
            end
            if (do_retire_s) begin
                head_r <= ptr_inc(head_r);
            end
            // Simultaneous issue and retire leave the occupancy unchanged.
            case ({can_issue_s, do_retire_s})
                2'b10:   alloc_count_r <= alloc_count_r + CNT_W'(1);
                2'b01:   alloc_count_r <= alloc_count_r - CNT_W'(1);
                default: alloc_count_r <= alloc_count_r;
            endcase
        end
    end

    // Frame FSM with issue/retire coordinate counters and the frame_done pulse.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r      <= ST_IDLE;
            x_r          <= '0;
            y_r          <= '0;
            rx_r         <= '0;
            ry_r         <= '0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (can_issue_s) begin
                if (x_r == X_LAST) begin
                    x_r <= '0;
                    y_r <= (y_r == Y_LAST) ? '0 : y_r + 9'd1;
                end else begin
                    x_r <= x_r + 10'd1;
                end
            end
            if (do_retire_s) begin
                if (rx_r == X_LAST) begin
                    rx_r <= '0;
                    ry_r <= (ry_r == Y_LAST) ? '0 : ry_r + 9'd1;
                end else begin
                    rx_r <= rx_r + 10'd1;
                end
            end
            case (state_r)
                ST_IDLE: begin
                    if (enable) begin
                        state_r <= ST_RUN;
                        x_r     <= '0;
                        y_r     <= '0;
                        rx_r    <= '0;
                        ry_r    <= '0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (can_issue_s && last_pix_s) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done_s) begin
                        state_r      <= ST_IDLE;
                        frame_done_r <= 1'b1;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ray_dispatcher.sv
// Bench for ray_dispatcher on a 4x2 screen with 2 lanes and a 4-slot ROB.
// A pixel-level reference model (counts of issued/retired pixels, per-pixel
// "result returned" flags, lane occupancy) predicts every output each cycle.
module tb_ray_dispatcher;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NU   = 2;
    localparam int RD   = 4;
    localparam int NPIX = W * H;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              enable = 1'b0;
    logic              ready = 1'b0;
    logic [9:0]        issue_x;
    logic [8:0]        issue_y;
    logic [NU-1:0]     issue_valid;
    logic [NU-1:0]     unit_ready = '0;
    logic [NU-1:0]     res_valid = '0;
    logic [24*NU-1:0]  res_rgb = '0;
    logic [7:0]        r, g, b;
    logic              valid, sof, eol, busy, frame_done;

    always #5 aclk = ~aclk;

    ray_dispatcher #(.NUM_UNITS(NU), .ROB_DEPTH(RD), .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable),
        .issue_x(issue_x), .issue_y(issue_y), .issue_valid(issue_valid),
        .unit_ready(unit_ready), .res_valid(res_valid), .res_rgb(res_rgb),
        .r(r), .g(g), .b(b), .valid(valid), .ready(ready),
        .sof(sof), .eol(eol), .busy(busy), .frame_done(frame_done)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model: phase 0 = idle, 1 = issuing, 2 = waiting for last retire
    int m_phase = 0, m_issued = 0, m_retired = 0, m_rr = 0;
    bit m_fd = 1'b0;
    bit m_ret [NPIX];
    // lane model
    bit l_busy [NU];
    bit l_stale [NU];
    int l_cnt [NU];
    int l_pix [NU];
    int dly_lo [NU];
    int dly_hi [NU];
    // stimulus knobs
    bit en_req = 1'b0, rst_req = 1'b1, spur_req = 1'b0;
    int ready_mode = 0;
    // observations of the DUT stream
    int obs_ret, obs_sof, obs_eol, obs_fd, obs_iss;
    logic [23:0] obs_first, obs_last;

    function automatic logic [23:0] pix_rgb(input int p);
        return {8'(p % W), 8'(p / W), 8'hA5};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clear_obs();
        obs_ret = 0; obs_sof = 0; obs_eol = 0; obs_fd = 0; obs_iss = 0;
        obs_first = '0; obs_last = '0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step();
        logic [NU-1:0] fire;
        int exp_lane, pre_phase, pre_ret, lane;
        bit exp_valid;
        @(negedge aclk);
        cyc++;
        aresetn = !rst_req;
        enable  = en_req;
        case (ready_mode)
            0:       ready = 1'b1;
            1:       ready = 1'b0;
            default: ready = 1'($urandom_range(1, 0));
        endcase
        fire = '0; res_valid = '0; res_rgb = '0;
        for (int i = 0; i < NU; i++) begin
            unit_ready[i] = !l_busy[i];
            if (l_busy[i] && l_cnt[i] == 0) begin
                fire[i] = 1'b1;
                res_valid[i] = 1'b1;
                res_rgb[24*i +: 24] = pix_rgb(l_pix[i]);
            end
        end
        if (spur_req && !l_busy[1]) begin
            res_valid[1] = 1'b1;
            res_rgb[47:24] = 24'hDEAD5A;
            spur_req = 1'b0;
        end
        #1;
        if (!aresetn) begin
            m_phase = 0; m_issued = 0; m_retired = 0; m_rr = 0; m_fd = 1'b0;
            for (int p = 0; p < NPIX; p++) m_ret[p] = 1'b0;
            for (int i = 0; i < NU; i++) if (l_busy[i]) l_stale[i] = 1'b1;
        end
        exp_lane = -1;
        if (m_phase == 1 && (m_issued - m_retired) < RD) begin
            for (int k = 0; k < NU; k++) begin
                lane = (m_rr + k) % NU;
                if (exp_lane < 0 && unit_ready[lane]) exp_lane = lane;
            end
        end
        exp_valid = (m_retired < m_issued) && m_ret[m_retired];

        chk("issue_valid", 32'(issue_valid), (exp_lane >= 0) ? (32'd1 << exp_lane) : 32'd0);
        if (exp_lane >= 0) begin
            chk("issue_x", 32'(issue_x), 32'(m_issued % W));
            chk("issue_y", 32'(issue_y), 32'(m_issued / W));
        end
        chk("valid", 32'(valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("rgb", 32'({r, g, b}), 32'(pix_rgb(m_retired)));
            chk("sof", 32'(sof), 32'(m_retired == 0));
            chk("eol", 32'(eol), 32'((m_retired % W) == W - 1));
        end else if (!aresetn) begin
            chk("rst_rgb", 32'({r, g, b}), 32'd0);
            chk("rst_sof_eol", 32'({sof, eol}), 32'd0);
            chk("rst_issue_xy", 32'({issue_x, issue_y}), 32'd0);
        end
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("frame_done", 32'(frame_done), 32'(m_fd));

        if (aresetn && valid && ready) begin
            obs_ret++;
            if (obs_ret == 1) obs_first = {r, g, b};
            obs_last = {r, g, b};
            if (sof) obs_sof++;
            if (eol) obs_eol++;
        end
        if (frame_done) obs_fd++;
        if (issue_valid != '0) obs_iss++;

        for (int i = 0; i < NU; i++) begin
            if (fire[i]) begin
                l_busy[i] = 1'b0;
                if (!l_stale[i] && aresetn) m_ret[l_pix[i]] = 1'b1;
            end else if (l_busy[i]) begin
                l_cnt[i]--;
            end
        end
        if (aresetn) begin
            pre_phase = m_phase;
            pre_ret   = m_retired;
            m_fd      = 1'b0;
            if (exp_valid && ready) m_retired++;
            if (exp_lane >= 0) begin
                l_busy[exp_lane]  = 1'b1;
                l_stale[exp_lane] = 1'b0;
                l_cnt[exp_lane]   = int'($urandom_range(dly_hi[exp_lane], dly_lo[exp_lane])) - 1;
                l_pix[exp_lane]   = m_issued;
                m_issued++;
                m_rr = (exp_lane + 1) % NU;
                if (m_issued == NPIX) m_phase = 2;
            end
            if (pre_phase == 2 && pre_ret == NPIX) begin
                m_phase = 0;
                m_fd    = 1'b1;
            end
            if (pre_phase == 0 && enable) begin
                m_phase = 1; m_issued = 0; m_retired = 0;
                for (int p = 0; p < NPIX; p++) m_ret[p] = 1'b0;
            end
        end
    endtask

    task automatic finish_frame(input int budget);
        int n;
        n = 0;
        while (m_phase != 0 && n < budget) begin
            step();
            n++;
        end
        step();
        chk("busy_after_frame", 32'(busy), 32'd0);
    endtask

    task automatic run_frame(input int budget);
        en_req = 1'b1;
        step();
        en_req = 1'b0;
        finish_frame(budget);
    endtask

    task automatic set_dly(input int lo0, input int hi0, input int lo1, input int hi1);
        dly_lo[0] = lo0; dly_hi[0] = hi0; dly_lo[1] = lo1; dly_hi[1] = hi1;
    endtask

    initial begin
        int n;
        for (int i = 0; i < NU; i++) begin
            l_busy[i] = 1'b0; l_stale[i] = 1'b0; l_cnt[i] = 0; l_pix[i] = 0;
        end
        for (int p = 0; p < NPIX; p++) m_ret[p] = 1'b0;
        set_dly(3, 3, 3, 3);
        clear_obs();

        // reset state
        rst_req = 1'b1;
        repeat (3) step();
        rst_req = 1'b0;
        repeat (2) step();

        // equal delays, ready always high
        clear_obs();
        run_frame(200);
        chk("t1_retired", 32'(obs_ret), 32'd8);
        chk("t1_sof_count", 32'(obs_sof), 32'd1);
        chk("t1_eol_count", 32'(obs_eol), 32'd2);
        chk("t1_first_pix", 32'(obs_first), 32'h0000A5);
        chk("t1_last_pix", 32'(obs_last), 32'h0301A5);

        // enable was a one-cycle pulse: stay idle afterwards
        repeat (10) step();
        chk("t1_frame_done_pulses", 32'(obs_fd), 32'd1);

        // lane 0 slow, lane 1 fast: out-of-order return
        set_dly(10, 10, 1, 1);
        clear_obs();
        run_frame(300);
        chk("t2_retired", 32'(obs_ret), 32'd8);
        chk("t2_first_pix", 32'(obs_first), 32'h0000A5);

        // ready held low for 20 cycles: ROB fills after 4 allocations
        set_dly(3, 3, 3, 3);
        clear_obs();
        ready_mode = 1;
        en_req = 1'b1;
        step();
        en_req = 1'b0;
        repeat (20) step();
        chk("t3_stall_issues", 32'(obs_iss), 32'd4);
        ready_mode = 0;
        finish_frame(200);
        chk("t3_retired", 32'(obs_ret), 32'd8);

        // reset after the third issue, late results must be ignored
        set_dly(6, 6, 6, 6);
        en_req = 1'b1;
        step();
        en_req = 1'b0;
        n = 0;
        while (m_issued < 3 && n < 50) begin
            step();
            n++;
        end
        chk("t5_reached_3_issues", 32'(m_issued >= 3), 32'd1);
        rst_req = 1'b1;
        repeat (2) step();
        rst_req = 1'b0;
        repeat (8) step();
        set_dly(2, 2, 2, 2);
        clear_obs();
        run_frame(200);
        chk("t5_retired", 32'(obs_ret), 32'd8);
        chk("t5_first_pix", 32'(obs_first), 32'h0000A5);
        chk("t5_sof_count", 32'(obs_sof), 32'd1);

        // spurious result strobe on an idle lane 1
        set_dly(4, 4, 4, 4);
        clear_obs();
        en_req = 1'b1;
        step();
        en_req = 1'b0;
        spur_req = 1'b1;
        finish_frame(200);
        chk("t6_retired", 32'(obs_ret), 32'd8);
        chk("t6_last_pix", 32'(obs_last), 32'h0301A5);

        // randomized delays and backpressure over several frames
        ready_mode = 2;
        set_dly(1, 9, 1, 9);
        for (int f = 0; f < 6; f++) begin
            clear_obs();
            run_frame(600);
            chk("rand_retired", 32'(obs_ret), 32'd8);
            repeat (int'($urandom_range(3, 0))) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ray_dispatcher.md
# ray_dispatcher

Scheduler between the pixel-coordinate counter and a bank of `ray_unit` lanes in the ray marcher pixel generator. Walks the screen in raster order and issues each pixel coordinate to whichever lane is free (round-robin). Collects shaded results, which may return out of order, in a reorder buffer (ROB). Retires pixels to the packer strictly in raster order with `sof`/`eol` framing.

## Interface
Parameters:
- `NUM_UNITS`, 4: number of ray lanes, 1..8
- `ROB_DEPTH`, 8: reorder slots; power of two, ≥ `NUM_UNITS`
- `SCREEN_WIDTH`, 640: pixels per line
- `SCREEN_HEIGHT`, 480: lines per frame

Ports (clock and reset first):
- `aclk`  in  1  sole clock
- `aresetn`  in  1  asynchronous, active-low reset
- `enable`  in  1  permit starting a new frame
- `issue_x`  out  10  x coordinate broadcast to all lanes
- `issue_y`  out  9  y coordinate broadcast to all lanes
- `issue_valid`  out  NUM_UNITS  one-hot lane select for the current issue
- `unit_ready`  in  NUM_UNITS  lane idle, can accept a coordinate
- `res_valid`  in  NUM_UNITS  lane result strobe, one cycle
- `res_rgb`  in  24*NUM_UNITS  lane results, lane i at bits [24i+:24], ordered {r,g,b}
- `r`, `g`, `b`  out  8 each  retired pixel
- `valid`  out  1  retired pixel valid (drives packer `valid`)
- `ready`  in  1  packer `in_stream_ready`
- `sof`  out  1  retiring pixel is (0,0)
- `eol`  out  1  retiring pixel has x = SCREEN_WIDTH-1
- `busy`  out  1  state ≠ IDLE
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame retires

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: when `enable` = 1, clear the issue and retire counters and go to RUN.
  - RUN: issue one pixel per cycle when allowed. When the issue handshake for pixel (W-1, H-1) completes, go to DRAIN.
  - DRAIN: when the ROB is empty and there are no outstanding lanes, pulse `frame_done` and go to IDLE.
- `enable` is sampled only in IDLE. Deasserting it mid-frame lets the frame complete.
- Issue rule: in RUN with `alloc_count < ROB_DEPTH`, select the first lane with `unit_ready` = 1, searching from `rr_ptr` upward with wraparound.
  - Assert that lane's `issue_valid` bit. The handshake completes in the same cycle.
  - On completion: store the ROB tail index in `unit_tag[i]`, set `unit_busy[i]`, advance the tail, set `rr_ptr` to i+1 mod NUM_UNITS, and advance x/y.
- Coordinate counters: x wraps at W-1 to 0 and increments y; y wraps at H-1.
- Result capture: for each lane with `res_valid[i]` and `unit_busy[i]`, write `res_rgb[i]` into `rob[unit_tag[i]]`, set its filled bit, and clear `unit_busy[i]`.
  - All lanes can write in the same cycle; tags are distinct.
  - A `res_valid` from a non-busy lane is ignored.
- Retire: `valid` = `filled[head]`. On `valid & ready`, clear the filled bit, increment head, and advance the retire x/y counters.
  - `sof` and `eol` are decoded from the retire counters.
- `alloc_count` tracks slots from issue to retire:
  - +1 on issue, -1 on retire.
  - Unchanged when issue and retire happen in the same cycle.
- All pointers are modulo `ROB_DEPTH`.

## Timing
- Reset values: all outputs 0. State IDLE; head = tail = 0; `rr_ptr` = 0; `alloc_count` = 0; all filled and busy bits cleared.
- `issue_valid`, `issue_x` and `issue_y` are combinational from registered state and `unit_ready`. There is zero-cycle accept.
- Result to `valid`: 1 cycle when the slot is at head.
- `valid`, `r`/`g`/`b`, `sof` and `eol` hold stable while `valid & !ready`.
- Throughput: 1 pixel/cycle at most on both issue and retire.
- ROB full (`alloc_count = ROB_DEPTH`): `issue_valid` = 0. A retire in the same cycle unblocks issue on the next cycle, not the same cycle.
- `frame_done` is asserted the cycle after DRAIN exits, coincident with IDLE.
- An `aresetn` assertion mid-frame discards all in-flight state immediately. Lane results arriving after reset are ignored.

## Structure
- The shared package holds:
  - `SCREEN_WIDTH` and `SCREEN_HEIGHT` defaults (from `common_defs`).
  - `rgb_t` packed struct {r,g,b}.
  - FSM state enum `disp_state_t`.
- Natural sub-module: `rr_picker`, a combinational round-robin first-one finder over `unit_ready` from `rr_ptr`. The ROB stays inline.

## Test plan
Bench setup: W=4, H=2, NUM_UNITS=2, ROB_DEPTH=4. Lane model returns result = {x, y, 8'hA5} after a programmable delay.
- Equal 3-cycle delays, `ready` = 1 → 8 pixels retire in raster order; `sof` only on (0,0); `eol` on x=3 twice; `frame_done` pulses once; `busy` falls.
- Lane 0 delay 10, lane 1 delay 1 → lane 1 results are held in the ROB; output order is still (0,0),(1,0),(2,0)…; no slot is overwritten.
- `ready` held 0 for 20 cycles → issue stops after 4 allocations; `issue_valid` = 0; outputs stable; the frame completes normally after release.
- `enable` pulsed for one cycle, then 0 → exactly one frame runs; the FSM remains IDLE afterwards.
- `aresetn` asserted after the 3rd issue → all outputs 0 immediately; a late `res_valid` is ignored; a fresh frame after release starts at (0,0) with `sof`.
- Spurious `res_valid[1]` while lane 1 is not busy → no ROB change; output sequence unaffected.
